// File: rtl/btn_ctrl_pkg.sv
// Shared definitions for the button/switch control blocks: debounce state encodings
// and compile-time sizing helpers.
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    DbOff   = 2'd0,
    DbToOn  = 2'd1,
    DbOn    = 2'd2,
    DbToOff = 2'd3
  } db_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  localparam int unsigned DefaultDiv = div_of(50_000_000, 1_000);

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle pulse every CLK_HZ/TICK_HZ clocks.
module tick_gen
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1_000
) (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_pls_1k
);

  localparam int unsigned Div  = div_of(CLK_HZ, TICK_HZ);
  localparam int unsigned CntW = clog2(Div);
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    o_pls_1k = (cnt_q == CntMax);
    cnt_d    = o_pls_1k ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/go_btn_ctrl.sv
// Button front end for the LED blink block: timebase tick, synchronised and debounced
// button, press pulse, and a run-enable level toggled by each press.
module go_btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 1_000,
  parameter int unsigned DEB_TICKS   = 20,
  parameter bit          BTN_ACT_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_btn,
  input  logic i_clr,
  output logic o_pls_1k,
  output logic o_btn_db,
  output logic o_press,
  output logic o_go
);

  localparam logic RawIdle = BTN_ACT_LOW ? 1'b1 : 1'b0;
  localparam int unsigned DebW = clog2(DEB_TICKS + 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_TICKS - 1);

  logic            pls;
  logic [1:0]      sync_q;
  logic            s_btn;
  db_state_e       state_q, state_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            btn_db_q, btn_db_d;
  logic            press_q, press_d;
  logic            go_q, go_d;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .o_pls_1k(pls)
  );

  assign s_btn = BTN_ACT_LOW ? ~sync_q[1] : sync_q[1];

  // Accepting on the tick that would bring the count to DEB_TICKS.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    btn_db_d  = btn_db_q;
    press_d   = 1'b0;
    unique case (state_q)
      DbOff: begin
        if (s_btn) begin
          state_d   = DbToOn;
          deb_cnt_d = '0;
        end
      end
      DbToOn: begin
        if (!s_btn) begin
          state_d   = DbOff;
          deb_cnt_d = '0;
        end else if (pls) begin
          if (deb_cnt_q == DebLast) begin
            state_d   = DbOn;
            deb_cnt_d = '0;
            btn_db_d  = 1'b1;
            press_d   = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
          end
        end
      end
      DbOn: begin
        if (!s_btn) begin
          state_d   = DbToOff;
          deb_cnt_d = '0;
        end
      end
      DbToOff: begin
        if (s_btn) begin
          state_d   = DbOn;
          deb_cnt_d = '0;
        end else if (pls) begin
          if (deb_cnt_q == DebLast) begin
            state_d   = DbOff;
            deb_cnt_d = '0;
            btn_db_d  = 1'b0;
          end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
          end
        end
      end
      default: begin
        state_d   = DbOff;
        deb_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    go_d = go_q;
    if (i_clr) begin
      go_d = 1'b0;
    end else if (press_q) begin
      go_d = ~go_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q    <= {RawIdle, RawIdle};
      state_q   <= DbOff;
      deb_cnt_q <= '0;
      btn_db_q  <= 1'b0;
      press_q   <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_btn};
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      btn_db_q  <= btn_db_d;
      press_q   <= press_d;
      go_q      <= go_d;
    end
  end

  assign o_pls_1k = pls;
  assign o_btn_db = btn_db_q;
  assign o_press  = press_q;
  assign o_go     = go_q;

endmodule
